// File: rtl/mdu_issue_ctrl_if.sv
// Execute, MDU and writeback signals of the RV32M issue/writeback controller.
// master = controller, slave = execute stage / MDU / register file side.
interface mdu_issue_ctrl_if;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic        ex_flush;
    logic        ex_ready;
    logic        mdu_in_valid;
    logic [2:0]  mdu_funct3;
    logic [31:0] mdu_in_1;
    logic [31:0] mdu_in_2;
    logic        mdu_cpu_busy;
    logic [31:0] mdu_out;
    logic        mdu_out_valid;
    logic        mdu_busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;

    modport master (
        input  ex_valid, ex_instr, ex_rs1_data, ex_rs2_data, ex_flush,
        input  mdu_out, mdu_out_valid, mdu_busy, wb_ready,
        output ex_ready, mdu_in_valid, mdu_funct3, mdu_in_1, mdu_in_2,
        output mdu_cpu_busy, wb_valid, wb_rd, wb_data
    );

    modport slave (
        output ex_valid, ex_instr, ex_rs1_data, ex_rs2_data, ex_flush,
        output mdu_out, mdu_out_valid, mdu_busy, wb_ready,
        input  ex_ready, mdu_in_valid, mdu_funct3, mdu_in_1, mdu_in_2,
        input  mdu_cpu_busy, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// RV32M issue/writeback controller: decodes M ops, issues to the MDU,
// tracks rd and buffers one result for the register file.
module mdu_issue_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mdu_issue_ctrl_if.master bus,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, DROP, WB} state_t;

    state_t      state_q, state_d;
    logic        is_m;
    logic [4:0]  rd;
    logic        issue;
    logic        capture;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    assign rd   = bus.ex_instr[11:7];
    assign is_m = bus.ex_valid
                & (bus.ex_instr[6:0] == 7'b0110011)
                & (bus.ex_instr[31:25] == 7'b0000001);

    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        capture      = 1'b0;
        bus.ex_ready = 1'b1;
        unique case (state_q)
            IDLE: begin
                // rd==x0 and flushed ops are consumed without issuing
                if (is_m && !bus.ex_flush && rd != 5'd0) begin
                    if (bus.mdu_busy) begin
                        bus.ex_ready = 1'b0;
                    end else begin
                        issue   = 1'b1;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                bus.ex_ready = !is_m;
                if (bus.mdu_out_valid) begin
                    capture = !bus.ex_flush;
                    state_d = bus.ex_flush ? IDLE : WB;
                end else if (bus.ex_flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                bus.ex_ready = !is_m;
                if (bus.mdu_out_valid)
                    state_d = IDLE;
            end
            WB: begin
                bus.ex_ready = !is_m;
                if (bus.wb_ready || bus.ex_flush)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
            op_cnt    <= '0;
        end else begin
            if (issue) begin
                wb_rd_q <= rd;
                op_cnt  <= op_cnt + CNT_W'(1);
            end
            if (capture)
                wb_data_q <= bus.mdu_out;
        end
    end

    assign bus.mdu_in_valid = issue;
    assign bus.mdu_funct3   = bus.ex_instr[14:12];
    assign bus.mdu_in_1     = bus.ex_rs1_data;
    assign bus.mdu_in_2     = bus.ex_rs2_data;
    assign bus.mdu_cpu_busy = (state_q == WB) & !bus.wb_ready;
    assign bus.wb_valid     = (state_q == WB);
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;

    // One result per issued op: a result outside WAIT/DROP is unexpected
    a_stray_result: assert property (@(posedge clk) disable iff (rst)
        bus.mdu_out_valid |-> (state_q == WAIT || state_q == DROP));

    a_issue_busy: assert property (@(posedge clk) disable iff (rst)
        bus.mdu_in_valid |-> !bus.mdu_busy);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl with an expected-writeback queue.
// Inputs change 1 time unit after posedge; checks happen mid-cycle.
module tb_mdu_issue_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] op_cnt;

    mdu_issue_ctrl_if bus ();

    mdu_issue_ctrl #(.CNT_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .op_cnt (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [36:0] exp_q[$];

    localparam logic [6:0] F7M = 7'b0000001;

    function automatic logic [31:0] rtype(input logic [6:0] f7,
                                          input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] a,
                         input logic [31:0] b);
        bus.ex_valid    = 1'b1;
        bus.ex_instr    = instr;
        bus.ex_rs1_data = a;
        bus.ex_rs2_data = b;
    endtask

    task automatic wb_pop(input string tag);
        logic [36:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_wb_rd"}, bus.wb_rd, e[36:32]);
            chk({tag, "_wb_data"}, bus.wb_data, e[31:0]);
        end
    endtask

    task automatic mdu_return(input logic [31:0] res);
        bus.mdu_out       = res;
        bus.mdu_out_valid = 1'b1;
        bus.mdu_busy      = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.ex_valid      = 1'b0;
        bus.ex_instr      = 32'd0;
        bus.ex_rs1_data   = 32'd0;
        bus.ex_rs2_data   = 32'd0;
        bus.ex_flush      = 1'b0;
        bus.mdu_out       = 32'd0;
        bus.mdu_out_valid = 1'b0;
        bus.mdu_busy      = 1'b0;
        bus.wb_ready      = 1'b1;
        #2;
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_rd", bus.wb_rd, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_op_cnt", op_cnt, 0);
        chk("rst_in_valid", bus.mdu_in_valid, 0);
        chk("rst_cpu_busy", bus.mdu_cpu_busy, 0);
        step();
        rst = 1'b0;

        // MUL x5 = 7*6
        drive(rtype(F7M, 3'b000, 5'd5), 32'd7, 32'd6);
        #1;
        chk("mul_in_valid", bus.mdu_in_valid, 1);
        chk("mul_ex_ready", bus.ex_ready, 1);
        chk("mul_funct3", bus.mdu_funct3, 3'b000);
        chk("mul_in_1", bus.mdu_in_1, 7);
        chk("mul_in_2", bus.mdu_in_2, 6);
        exp_q.push_back({5'd5, 32'd42});
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        bus.mdu_busy = 1'b1;
        #1;
        chk("mul_pulse_1cyc", bus.mdu_in_valid, 0);
        chk("mul_op_cnt", op_cnt, exp_cnt);
        drive(rtype(F7M, 3'b100, 5'd3), 32'd1, 32'd1);
        #1;
        chk("wait_ex_ready", bus.ex_ready, 0);
        chk("wait_in_valid", bus.mdu_in_valid, 0);
        step();
        bus.ex_valid = 1'b0;
        step();
        mdu_return(32'd42);
        #1;
        chk("mul_wb_not_yet", bus.wb_valid, 0);
        step();
        bus.mdu_out_valid = 1'b0;
        #1;
        chk("mul_wb_valid", bus.wb_valid, 1);
        wb_pop("mul");
        step();
        chk("mul_wb_done", bus.wb_valid, 0);

        // DIV x3 = 100/7 behind a busy MDU
        bus.mdu_busy = 1'b1;
        drive(rtype(F7M, 3'b100, 5'd3), 32'd100, 32'd7);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("div_stall_ready", bus.ex_ready, 0);
            chk("div_stall_issue", bus.mdu_in_valid, 0);
            step();
        end
        bus.mdu_busy = 1'b0;
        #1;
        chk("div_ex_ready", bus.ex_ready, 1);
        chk("div_in_valid", bus.mdu_in_valid, 1);
        chk("div_funct3", bus.mdu_funct3, 3'b100);
        exp_q.push_back({5'd3, 32'd14});
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        bus.mdu_busy = 1'b1;
        step();
        mdu_return(32'd14);
        step();
        bus.mdu_out_valid = 1'b0;
        #1;
        chk("div_wb_valid", bus.wb_valid, 1);
        wb_pop("div");
        step();

        // Flush in WAIT, extra flush in DROP, result discarded
        drive(rtype(F7M, 3'b000, 5'd7), 32'd3, 32'd3);
        #1;
        chk("fl_in_valid", bus.mdu_in_valid, 1);
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        bus.ex_flush = 1'b1;
        step();
        drive(rtype(F7M, 3'b000, 5'd8), 32'd1, 32'd1);
        #1;
        chk("drop_ex_ready", bus.ex_ready, 0);
        chk("drop_in_valid", bus.mdu_in_valid, 0);
        step();
        bus.ex_flush = 1'b0;
        bus.ex_valid = 1'b0;
        mdu_return(32'hDEADBEEF);
        step();
        bus.mdu_out_valid = 1'b0;
        #1;
        chk("fl_no_wb", bus.wb_valid, 0);
        chk("fl_op_cnt", op_cnt, exp_cnt);

        // MULH x9 = hi(-2*3)
        drive(rtype(F7M, 3'b001, 5'd9), 32'hFFFFFFFE, 32'd3);
        #1;
        chk("mulh_in_valid", bus.mdu_in_valid, 1);
        chk("mulh_funct3", bus.mdu_funct3, 3'b001);
        exp_q.push_back({5'd9, 32'hFFFFFFFF});
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        step();
        mdu_return(32'hFFFFFFFF);
        step();
        bus.mdu_out_valid = 1'b0;
        #1;
        chk("mulh_wb_valid", bus.wb_valid, 1);
        wb_pop("mulh");
        step();

        // Flush coinciding with the result
        drive(rtype(F7M, 3'b011, 5'd10), 32'd9, 32'd9);
        #1;
        chk("mulhu_in_valid", bus.mdu_in_valid, 1);
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        step();
        bus.ex_flush = 1'b1;
        mdu_return(32'h1234);
        step();
        bus.ex_flush      = 1'b0;
        bus.mdu_out_valid = 1'b0;
        #1;
        chk("flv_no_wb", bus.wb_valid, 0);

        // REM x11 = 17%5, register file stalls 4 cycles
        drive(rtype(F7M, 3'b110, 5'd11), 32'd17, 32'd5);
        #1;
        chk("rem_in_valid", bus.mdu_in_valid, 1);
        exp_q.push_back({5'd11, 32'd2});
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        step();
        mdu_return(32'd2);
        bus.wb_ready = 1'b0;
        step();
        bus.mdu_out_valid = 1'b0;
        drive(rtype(F7M, 3'b000, 5'd12), 32'd4, 32'd5);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_wb_valid", bus.wb_valid, 1);
            chk("bp_wb_rd", bus.wb_rd, 11);
            chk("bp_wb_data", bus.wb_data, 2);
            chk("bp_cpu_busy", bus.mdu_cpu_busy, 1);
            chk("bp_ex_ready", bus.ex_ready, 0);
            chk("bp_in_valid", bus.mdu_in_valid, 0);
            step();
        end
        bus.wb_ready = 1'b1;
        #1;
        chk("bp_cpu_busy_rel", bus.mdu_cpu_busy, 0);
        chk("bp_hs_in_valid", bus.mdu_in_valid, 0);
        wb_pop("rem");
        step();
        chk("next_wb_clear", bus.wb_valid, 0);
        chk("next_in_valid", bus.mdu_in_valid, 1);
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        #1;
        chk("next_op_cnt", op_cnt, exp_cnt);

        // Asynchronous reset while waiting on the MDU
        rst = 1'b1;
        #1;
        chk("arst_op_cnt", op_cnt, 0);
        chk("arst_wb_rd", bus.wb_rd, 0);
        chk("arst_wb_data", bus.wb_data, 0);
        chk("arst_wb_valid", bus.wb_valid, 0);
        chk("arst_in_valid", bus.mdu_in_valid, 0);
        chk("arst_cpu_busy", bus.mdu_cpu_busy, 0);
        exp_cnt = 0;
        step();
        rst = 1'b0;

        // MUL x0 and ADD: consumed, nothing issued
        drive(rtype(F7M, 3'b000, 5'd0), 32'd1, 32'd2);
        #1;
        chk("x0_ex_ready", bus.ex_ready, 1);
        chk("x0_in_valid", bus.mdu_in_valid, 0);
        step();
        chk("x0_op_cnt", op_cnt, exp_cnt);
        drive(rtype(7'b0000000, 3'b000, 5'd5), 32'd1, 32'd2);
        #1;
        chk("add_ex_ready", bus.ex_ready, 1);
        chk("add_in_valid", bus.mdu_in_valid, 0);
        step();
        chk("add_op_cnt", op_cnt, exp_cnt);

        // MUL x6 = 2*3, then flushed while presented
        drive(rtype(F7M, 3'b000, 5'd6), 32'd2, 32'd3);
        #1;
        chk("mul6_in_valid", bus.mdu_in_valid, 1);
        exp_q.push_back({5'd6, 32'd6});
        exp_cnt++;
        step();
        bus.ex_valid = 1'b0;
        step();
        mdu_return(32'd6);
        bus.wb_ready = 1'b0;
        step();
        bus.mdu_out_valid = 1'b0;
        #1;
        chk("mul6_wb_valid", bus.wb_valid, 1);
        wb_pop("mul6");
        chk("mul6_op_cnt", op_cnt, exp_cnt);
        bus.ex_flush = 1'b1;
        step();
        bus.ex_flush = 1'b0;
        bus.wb_ready = 1'b1;
        #1;
        chk("wbflush_wb_valid", bus.wb_valid, 0);
        chk("wbflush_cpu_busy", bus.mdu_cpu_busy, 0);

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue and writeback controller sitting directly upstream and downstream of the M-extension MDU (multiply/divide unit).
- Decodes RV32M instructions from the execute stage and presents operands/funct3 to the MDU with a single-cycle valid pulse.
- Tracks the destination register and captures the MDU result into a one-entry writeback buffer with a valid/ready handshake.
- Stalls the execute stage while an op is outstanding; supports pipeline flush of an in-flight op.

Parameters:
- CNT_W, 32, width of the issued-operation performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  execute stage presents an instruction
- ex_instr  in  32  instruction word
- ex_rs1_data  in  32  x[rs1]
- ex_rs2_data  in  32  x[rs2]
- ex_flush  in  1  kill any accepted/in-flight M op
- ex_ready  out  1  instruction consumed this cycle (0 = stall execute)
- mdu_in_valid  out  1  one-cycle issue pulse to MDU
- mdu_funct3  out  3  funct3 to MDU
- mdu_in_1  out  32  multiplicand/dividend
- mdu_in_2  out  32  multiplier/divisor
- mdu_cpu_busy  out  1  downstream back-pressure to MDU
- mdu_out  in  32  MDU result
- mdu_out_valid  in  1  MDU result valid (one cycle)
- mdu_busy  in  1  MDU occupied
- wb_valid  out  1  result pending for register file
- wb_rd  out  5  destination register
- wb_data  out  32  result
- wb_ready  in  1  register file accepts result
- op_cnt  out  CNT_W  count of ops issued to MDU (wraps)

Behaviour:
- Decode: is_m = ex_valid & opcode==7'b0110011 & funct7==7'b0000001. For non-M instructions, ex_ready=1 and the block takes no action.
- mdu_funct3 = instr[14:12]. mdu_in_1 = ex_rs1_data and mdu_in_2 = ex_rs2_data, combinational pass-through.
- FSM states: IDLE, WAIT, DROP, WB. Reset state: IDLE.
- Reset values: wb_valid=0, wb_rd=0, wb_data=0, op_cnt=0, mdu_in_valid=0, mdu_cpu_busy=0.
- IDLE:
  - issue = is_m & rd!=0 & !mdu_busy & !ex_flush. On issue: mdu_in_valid=1, ex_ready=1, latch rd, op_cnt+1, go to WAIT.
  - is_m & rd==0: consumed with ex_ready=1 and no issue (result architecturally discarded); stay IDLE.
  - is_m & mdu_busy: ex_ready=0.
  - is_m & ex_flush: ex_ready=1, no issue.
- WAIT:
  - ex_ready=0 for M instructions.
  - mdu_out_valid: capture wb_data=mdu_out, wb_valid=1, go to WB; result visible the cycle after mdu_out_valid.
  - ex_flush without mdu_out_valid: go to DROP.
  - ex_flush with mdu_out_valid in the same cycle: discard the result, go to IDLE.
- DROP:
  - ex_ready=0 for M instructions.
  - Wait for mdu_out_valid, discard it, go to IDLE. Further ex_flush has no effect.
- WB:
  - wb_valid=1; ex_ready=0 for M instructions.
  - wb_valid & wb_ready: clear wb_valid, go to IDLE. The next M op issues no earlier than the following cycle, so back-to-back issue spacing is ≥1 cycle after writeback.
  - ex_flush: clear wb_valid, go to IDLE. A result already presented counts as committed only if wb_ready is high in the same cycle; flush does not cancel a completed handshake.
- mdu_cpu_busy = (state==WB) & !wb_ready.
- mdu_in_valid is never asserted outside IDLE, and never while mdu_busy=1.
- Exactly one result is expected per issued op. An mdu_out_valid in IDLE or WB is ignored. A stray mdu_out_valid is a protocol error; assert it in simulation.
- wb_rd and wb_data hold their values while wb_valid=1.
- Reset mid-operation returns to IDLE immediately. The MDU is reset by the same rst.
- op_cnt wraps modulo 2^CNT_W.

Test Plan:
- MUL x5,x1,x2 with rs1=7, rs2=6, MDU returns 42 after N cycles → mdu_in_valid pulse of 1 cycle with funct3=000; wb_valid with wb_rd=5 and wb_data=42 the cycle after mdu_out_valid; op_cnt=1.
- DIV x3 with mdu_busy=1 for 3 cycles → ex_ready=0 for 3 cycles, then issue on the 4th; mdu_funct3=100.
- Flush in WAIT, then MDU returns 0xDEADBEEF → no wb_valid; return to IDLE; a following MULH issues normally.
- Result captured with wb_ready=0 for 4 cycles → wb_valid, wb_rd and wb_data stable; mdu_cpu_busy=1; the next M op is stalled until the handshake completes.
- MUL x0,x1,x2 → ex_ready=1, no mdu_in_valid, op_cnt unchanged. ADD (funct7=0) → ex_ready=1, no action.
- rst asserted in WAIT → all outputs at reset values asynchronously; FSM in IDLE; op_cnt=0.
